// File: rtl/eth_packet_gen.sv
// eth_packet_gen: byte-serial Ethernet frame generator.
// On an accepted start it emits preamble, SFD, DST MAC, SRC MAC, EtherType,
// a counting payload (seed, seed+1, ...) and, when ETH_GEN_FCS_EN is defined,
// a CRC-32 FCS, then holds busy through a programmable inter-frame gap.
// Handshake: a byte transfers on a rising clk edge where tx_valid && tx_ready;
// tx_data/tx_sof/tx_eof are held unchanged while tx_valid is high and
// tx_ready is low, and tx_valid never depends on tx_ready.
// Optional feature macro: ETH_GEN_FCS_EN (appends a 4-byte CRC-32 FCS).
module eth_packet_gen #(
  parameter logic [47:0] DST_MAC    = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC    = 48'h0011_2233_4455,
  parameter logic [15:0] ETH_TYPE   = 16'h0800,
  parameter int unsigned IFG_CYCLES = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] len,
  input  logic [7:0] seed,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       tx_sof,
  output logic       tx_eof,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_SFD, S_DST, S_SRC, S_TYPE, S_PAY,
`ifdef ETH_GEN_FCS_EN
    S_FCS,
`endif
    S_IFG
  } state_t;

  // Field that follows the last payload/type byte.
`ifdef ETH_GEN_FCS_EN
  localparam state_t S_TAIL = S_FCS;
`else
  localparam state_t S_TAIL = S_IFG;
`endif

  localparam logic [7:0] IFG_LAST = 8'(IFG_CYCLES - 1);

  state_t     state_q, state_d, nxt;
  logic [7:0] idx_q;
  logic [7:0] len_q, seed_q;
  logic       last, step, advance;

  // MSB-first byte i of a 48-bit address (i = 0..5).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] i);
    logic [47:0] sh;
    sh = mac << {i, 3'b000};
    return sh[47:40];
  endfunction

`ifdef ETH_GEN_FCS_EN
  logic [31:0] crc_q, crc_inv;
  logic        crc_field;

  // Reflected CRC-32 update of one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  assign crc_inv   = ~crc_q;
  assign crc_field = (state_q == S_DST) || (state_q == S_SRC) ||
                     (state_q == S_TYPE) || (state_q == S_PAY);
`endif

  assign busy = (state_q != S_IDLE);

  // Next-state and byte outputs, decoded from the current field and its index.
  always_comb begin
    state_d  = state_q;
    nxt      = state_q;
    last     = 1'b0;
    step     = 1'b0;
    advance  = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    tx_sof   = 1'b0;
    tx_eof   = 1'b0;
    case (state_q)
      S_IDLE: begin
        nxt  = S_PRE;
        last = 1'b1;
        step = start;
      end
      S_PRE: begin
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        tx_sof   = (idx_q == 8'd0);
        last     = (idx_q == 8'd6);
        nxt      = S_SFD;
      end
      S_SFD: begin
        tx_valid = 1'b1;
        tx_data  = 8'hD5;
        last     = 1'b1;
        nxt      = S_DST;
      end
      S_DST: begin
        tx_valid = 1'b1;
        tx_data  = mac_byte(DST_MAC, idx_q[2:0]);
        last     = (idx_q == 8'd5);
        nxt      = S_SRC;
      end
      S_SRC: begin
        tx_valid = 1'b1;
        tx_data  = mac_byte(SRC_MAC, idx_q[2:0]);
        last     = (idx_q == 8'd5);
        nxt      = S_TYPE;
      end
      S_TYPE: begin
        tx_valid = 1'b1;
        tx_data  = (idx_q == 8'd0) ? ETH_TYPE[15:8] : ETH_TYPE[7:0];
        last     = (idx_q == 8'd1);
        nxt      = (len_q == 8'd0) ? S_TAIL : S_PAY;
`ifndef ETH_GEN_FCS_EN
        tx_eof   = last && (len_q == 8'd0);
`endif
      end
      S_PAY: begin
        tx_valid = 1'b1;
        tx_data  = seed_q + idx_q;
        last     = (idx_q == len_q - 8'd1);
        nxt      = S_TAIL;
`ifndef ETH_GEN_FCS_EN
        tx_eof   = last;
`endif
      end
`ifdef ETH_GEN_FCS_EN
      S_FCS: begin
        tx_valid = 1'b1;
        tx_data  = crc_inv[{idx_q[1:0], 3'b000} +: 8];
        last     = (idx_q == 8'd3);
        tx_eof   = last;
        nxt      = S_IFG;
      end
`endif
      S_IFG: begin
        last = (idx_q == IFG_LAST);
        step = 1'b1;
        nxt  = S_IDLE;
      end
      default: begin
        nxt  = S_IDLE;
        last = 1'b1;
        step = 1'b1;
      end
    endcase
    if (tx_valid) step = tx_ready;
    advance = step && last;
    if (advance) state_d = nxt;
  end

  // State, field index, start-time captures and completed-frame counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 8'd0;
      len_q     <= 8'd0;
      seed_q    <= 8'd0;
      frame_cnt <= 8'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        len_q  <= len;
        seed_q <= seed;
      end
      if (advance)   idx_q <= 8'd0;
      else if (step) idx_q <= idx_q + 8'd1;
      if (tx_valid && tx_ready && tx_eof) frame_cnt <= frame_cnt + 8'd1;
    end
  end

`ifdef ETH_GEN_FCS_EN
  // CRC over DST..PAY bytes as they are accepted; restarts with each frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q <= 32'hFFFF_FFFF;
    end else if (state_q == S_IDLE && start) begin
      crc_q <= 32'hFFFF_FFFF;
    end else if (tx_valid && tx_ready && crc_field) begin
      crc_q <= crc32_byte(crc_q, tx_data);
    end
  end
`endif

endmodule

// File: tb/tb_eth_packet_gen.sv
// tb_eth_packet_gen: directed, table-driven bench for eth_packet_gen.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_eth_packet_gen;

  localparam int IFG = 12;
`ifdef ETH_GEN_FCS_EN
  localparam int FCS_BYTES = 4;
`else
  localparam int FCS_BYTES = 0;
`endif

  logic       clk = 1'b0;
  logic       reset, start, tx_ready;
  logic [7:0] len, seed;
  logic [7:0] tx_data, frame_cnt;
  logic       tx_valid, tx_sof, tx_eof, busy;

  // Clock
  always #5 clk = ~clk;

  eth_packet_gen #(.IFG_CYCLES(IFG)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .seed(seed),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_sof(tx_sof), .tx_eof(tx_eof), .busy(busy), .frame_cnt(frame_cnt)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_frames = 8'd0;

  typedef struct {
    logic [7:0] len;
    logic [7:0] seed;
    int         mode;      // 0: ready always high, 1: ready pattern 1,0,0,1
    int         exp_len;   // frame bytes without FCS, hand computed
    logic [7:0] exp_last;  // last byte before FCS, hand computed
  } vec_t;
  vec_t vecs[9];

  // Scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

`ifdef ETH_GEN_FCS_EN
  function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if ((r[0] ^ d[i]) == 1'b1) r = (r >> 1) ^ 32'hEDB8_8320;
      else                       r = r >> 1;
    end
    return r;
  endfunction
`endif

  // Reference frame built from the field layout.
  task automatic build_expected(input logic [7:0] n, input logic [7:0] s);
    logic [7:0] hdr[15];
    hdr = '{8'hD5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
            8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h08, 8'h00};
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    for (int i = 0; i < 15; i++) exp_q.push_back(hdr[i]);
    for (int i = 0; i < int'(n); i++) exp_q.push_back(s + 8'(i));
`ifdef ETH_GEN_FCS_EN
    begin
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      for (int i = 8; i < exp_q.size(); i++) c = crc_model(c, exp_q[i]);
      c = ~c;
      for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
    end
`endif
  endtask

  function automatic logic [7:0] got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return 8'hxx;
  endfunction

  function automatic logic rdy(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    return (cyc % 4 == 0) || (cyc % 4 == 3);
  endfunction

  // Driver: one frame from IDLE, collecting accepted bytes and checking the gap.
  task automatic run_frame(input vec_t v);
    int cyc, sof_cnt, sof_pos, eof_cnt, eof_pos, stall_bad, k, vcnt;
    logic done, held_v;
    logic [7:0] held_d;
    logic held_s, held_e;
    got_q.delete();
    sof_cnt = 0; sof_pos = -1; eof_cnt = 0; eof_pos = -1; stall_bad = 0;
    held_v = 1'b0; held_d = 8'h00; held_s = 1'b0; held_e = 1'b0; done = 1'b0;
    build_expected(v.len, v.seed);
    len = v.len; seed = v.seed; start = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    len = 8'($urandom_range(0, 255));
    seed = 8'($urandom_range(0, 255));
    check("first_busy", busy, 1);
    check("first_sof", {tx_valid, tx_sof, tx_data}, {1'b1, 1'b1, 8'h55});
    cyc = 0;
    while (!done && cyc < 3000) begin
      tx_ready = rdy(v.mode, cyc);
      #1;
      if (tx_valid) begin
        if (held_v && (tx_data !== held_d || tx_sof !== held_s || tx_eof !== held_e))
          stall_bad++;
        if (tx_ready) begin
          if (tx_sof) begin sof_cnt++; sof_pos = got_q.size(); end
          if (tx_eof) begin eof_cnt++; eof_pos = got_q.size(); done = 1'b1; end
          got_q.push_back(tx_data);
          held_v = 1'b0;
        end else begin
          held_v = 1'b1; held_d = tx_data; held_s = tx_sof; held_e = tx_eof;
        end
      end
      if (!done) begin
        cyc++;
        start = (cyc == 5);   // mid-frame start pulse, must be ignored
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!done) check("frame_timeout", 1, 0);
    check("frame_len", got_q.size(), v.exp_len + FCS_BYTES);
    check("last_pay_byte", got_at(v.exp_len - 1), v.exp_last);
    begin
      int mism;
      mism = 0;
      for (int i = 0; i < exp_q.size(); i++) if (got_at(i) !== exp_q[i]) mism++;
      check("byte_mismatches", mism, 0);
    end
    check("sof_pos_cnt", {sof_pos[15:0], sof_cnt[15:0]}, {16'd0, 16'd1});
    check("eof_pos_cnt", {eof_pos[15:0], eof_cnt[15:0]}, {16'(exp_q.size() - 1), 16'd1});
    check("stall_stable", stall_bad, 0);
`ifdef ETH_GEN_FCS_EN
    begin
      logic [31:0] r;
      r = 32'hFFFF_FFFF;
      for (int i = 8; i < got_q.size(); i++) r = crc_model(r, got_q[i]);
      check("crc_residue", r, 32'hDEBB_20E3);
    end
`endif
    exp_frames = exp_frames + 8'd1;
    k = 0; vcnt = 0;
    do begin
      @(negedge clk);
      k++;
      if (tx_valid) vcnt++;
    end while (busy && k < 100);
    check("ifg_busy_drop", k, IFG + 1);
    check("ifg_no_valid", vcnt, 0);
    check("frame_cnt", frame_cnt, exp_frames);
    repeat (3) @(negedge clk);
    check("start_not_queued", {busy, tx_valid}, 2'b00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_frames = 8'd0;
    @(negedge clk);
  endtask

  // Watchdog
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Main sequence
  initial begin
    vecs[0] = '{8'd3,   8'hA0, 0, 25,  8'hA2};
    vecs[1] = '{8'd3,   8'hA0, 1, 25,  8'hA2};
    vecs[2] = '{8'd0,   8'h5A, 0, 22,  8'h00};
    vecs[3] = '{8'd2,   8'hFF, 0, 24,  8'h00};
    vecs[4] = '{8'd2,   8'hFF, 1, 24,  8'h00};
    vecs[5] = '{8'd46,  8'h00, 0, 68,  8'h2D};
    vecs[6] = '{8'd46,  8'h00, 1, 68,  8'h2D};
    vecs[7] = '{8'd255, 8'h10, 1, 277, 8'h0E};
    vecs[8] = '{8'd1,   8'h80, 0, 23,  8'h80};

    reset = 1'b1; start = 1'b0; tx_ready = 1'b0; len = 8'd0; seed = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {tx_data, tx_valid, tx_sof, tx_eof, busy, frame_cnt},
          {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    reset = 1'b0;
    @(negedge clk);
    check("idle_no_start", {busy, tx_valid}, 2'b00);

    for (int i = 0; i < 9; i++) run_frame(vecs[i]);

    // start held high for three frames: back-to-back with fixed gap
    do_reset();
    begin
      int frames, idle_run, nbytes, cyc;
      frames = 0; idle_run = 0; nbytes = 0; cyc = 0;
      start = 1'b1; len = 8'd1; seed = 8'h07; tx_ready = 1'b1;
      while (frames < 3 && cyc < 1000) begin
        @(negedge clk);
        cyc++;
        if (tx_valid) begin
          if (idle_run > 0 && frames > 0) check("held_gap", idle_run, IFG + 1);
          idle_run = 0;
          nbytes++;
          if (tx_eof) begin
            frames++;
            check("held_frame_len", nbytes, 23 + FCS_BYTES);
            nbytes = 0;
          end
        end else begin
          idle_run++;
        end
      end
      start = 1'b0;
      check("held_frames_seen", frames, 3);
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (busy && cyc < 100);
      check("held_frame_cnt", frame_cnt, 3);
    end

    // reset asserted while payload byte 1 is presented
    do_reset();
    start = 1'b1; len = 8'd4; seed = 8'h30; tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (23) @(negedge clk);
    check("pre_reset_pay1", {tx_valid, tx_data}, {1'b1, 8'h31});
    reset = 1'b1;
    @(negedge clk);
    check("midreset_outputs", {tx_data, tx_valid, tx_sof, tx_eof, busy, frame_cnt},
          {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    reset = 1'b0;
    exp_frames = 8'd0;
    @(negedge clk);
    run_frame('{8'd4, 8'h30, 0, 26, 8'h33});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
